// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: the C64 host cycle and the DMA slot handshake.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [7:0]            host_wdata;
    logic [7:0]            host_rdata;
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [7:0]            dma_wdata;
    logic [7:0]            dma_rdata;
    logic                  dma_done;
    logic                  dma_abort;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  host_rdata, dma_rdata, dma_done, dma_abort
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output host_rdata, dma_rdata, dma_done, dma_abort
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the external 16-bit SRAM between the C64 host cycle (absolute priority)
// and one DMA requester that only uses idle gaps and is aborted when the host arrives.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 21,
    parameter int WE_DELAY   = 2,
    parameter int DMA_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  _reset,
    sram_arbiter_if.slave         req,
    output logic [ADDR_WIDTH-2:0] baddress,
    input  logic [15:0]           bdata_in,
    output logic [15:0]           bdata_out,
    output logic                  bdata_oe,
    output logic                  _ce_ram,
    output logic                  _we_mem,
    output logic                  _lb,
    output logic                  _ub
);

    typedef enum logic [1:0] {
        IDLE,
        HOST,
        DMA,
        RECOVER
    } state_t;

    localparam logic [3:0] CTR_MAX     = 4'd15;
    localparam logic [3:0] WE_START    = 4'(WE_DELAY);
    localparam logic [3:0] DMA_LAST    = 4'(DMA_CYCLES - 1);
    localparam logic [3:0] DMA_WE_LAST = 4'(DMA_CYCLES - 2);

    state_t     state;
    logic [3:0] ctr;
    logic       dma_done_q;
    logic       dma_abort_q;
    logic [7:0] dma_rdata_q;
    logic [7:0] host_rdata_c;
    logic [7:0] dma_lane;

    assign dma_lane = req.dma_addr[0] ? bdata_in[15:8] : bdata_in[7:0];

    // Arbitration FSM: ctr restarts on every state entry, so the default
    // saturating increment is overridden wherever a transition happens.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state       <= IDLE;
            ctr         <= 4'd0;
            dma_done_q  <= 1'b0;
            dma_abort_q <= 1'b0;
            dma_rdata_q <= 8'd0;
        end else begin
            dma_done_q  <= 1'b0;
            dma_abort_q <= 1'b0;
            if (ctr != CTR_MAX) begin
                ctr <= ctr + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (req.host_req) begin
                        state <= HOST;
                        ctr   <= 4'd0;
                    end else if (req.dma_req) begin
                        state <= DMA;
                        ctr   <= 4'd0;
                    end
                end
                HOST: begin
                    if (!req.host_req) begin
                        state <= RECOVER;
                        ctr   <= 4'd0;
                    end
                end
                DMA: begin
                    // The host always wins, even against the slot's final clock.
                    if (req.host_req) begin
                        state       <= HOST;
                        ctr         <= 4'd0;
                        dma_abort_q <= 1'b1;
                    end else if (ctr == DMA_LAST) begin
                        state      <= RECOVER;
                        ctr        <= 4'd0;
                        dma_done_q <= 1'b1;
                        if (!req.dma_we) begin
                            dma_rdata_q <= dma_lane;
                        end
                    end
                end
                RECOVER: begin
                    state <= req.host_req ? HOST : IDLE;
                    ctr   <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                    ctr   <= 4'd0;
                end
            endcase
        end
    end

    // SRAM pin decode from the current owner; the DMA write strobe is
    // withdrawn immediately when the host shows up mid-slot.
    always_comb begin
        baddress     = '0;
        bdata_out    = 16'd0;
        _ce_ram      = 1'b1;
        _we_mem      = 1'b1;
        _lb          = 1'b1;
        _ub          = 1'b1;
        host_rdata_c = 8'd0;
        case (state)
            HOST: begin
                baddress     = req.host_addr[ADDR_WIDTH-1:1];
                bdata_out    = {req.host_wdata, req.host_wdata};
                _ce_ram      = 1'b0;
                _we_mem      = !(req.host_we && (ctr >= WE_START));
                _lb          = req.host_addr[0];
                _ub          = !req.host_addr[0];
                host_rdata_c = req.host_addr[0] ? bdata_in[15:8] : bdata_in[7:0];
            end
            DMA: begin
                baddress  = req.dma_addr[ADDR_WIDTH-1:1];
                bdata_out = {req.dma_wdata, req.dma_wdata};
                _ce_ram   = 1'b0;
                _we_mem   = !(req.dma_we && !req.host_req &&
                              (ctr >= 4'd1) && (ctr <= DMA_WE_LAST));
                _lb       = req.dma_addr[0];
                _ub       = !req.dma_addr[0];
            end
            default: begin
                baddress = '0;
            end
        endcase
    end

    assign bdata_oe       = ~_we_mem;
    assign req.host_rdata = host_rdata_c;
    assign req.dma_rdata  = dma_rdata_q;
    assign req.dma_done   = dma_done_q;
    assign req.dma_abort  = dma_abort_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed timing scenarios, then random host/DMA traffic
// checked against a flat byte-memory reference through a scoreboard.
module tb_sram_arbiter;

    localparam int AW = 21;

    logic          clock  = 1'b0;
    logic          _reset = 1'b0;
    logic [AW-2:0] baddress;
    logic [15:0]   bdata_in;
    logic [15:0]   bdata_out;
    logic          bdata_oe;
    logic          _ce_ram;
    logic          _we_mem;
    logic          _lb;
    logic          _ub;

    sram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    sram_arbiter #(.ADDR_WIDTH(AW), .WE_DELAY(2), .DMA_CYCLES(3)) dut (
        .clock     (clock),
        ._reset    (_reset),
        .req       (bus.slave),
        .baddress  (baddress),
        .bdata_in  (bdata_in),
        .bdata_out (bdata_out),
        .bdata_oe  (bdata_oe),
        ._ce_ram   (_ce_ram),
        ._we_mem   (_we_mem),
        ._lb       (_lb),
        ._ub       (_ub)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       we;
        bit [7:0] exp;
    } dma_exp_t;

    bit [15:0]   mem [4096];
    bit [7:0]    ref_mem [8192];
    bit [7:0]    host_q[$];
    dma_exp_t    dma_q[$];
    logic        preload      = 1'b0;
    logic [11:0] preload_addr = 12'd0;
    logic [15:0] preload_data = 16'd0;
    int          checks       = 0;
    int          failures     = 0;
    bit          stop_mon     = 1'b0;

    // Behavioural SRAM: byte lanes written on the clock edge while CE and WE are low.
    always @(posedge clock) begin
        if (preload) begin
            mem[preload_addr] <= preload_data;
        end else if (!_ce_ram && !_we_mem) begin
            if (!_lb) mem[baddress[11:0]][7:0]  <= bdata_out[7:0];
            if (!_ub) mem[baddress[11:0]][15:8] <= bdata_out[15:8];
        end
    end

    assign bdata_in = mem[baddress[11:0]];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit hreq, input bit hwe, input logic [AW-1:0] haddr, input logic [7:0] hwdata);
        bus.host_req   = hreq;
        bus.host_we    = hwe;
        bus.host_addr  = haddr;
        bus.host_wdata = hwdata;
    endtask

    task automatic dmaStimulus(input bit dreq, input bit dwe, input logic [AW-1:0] daddr, input logic [7:0] dwdata);
        bus.dma_req   = dreq;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwdata;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.dma_done && n < budget);
        checkOutput(name, 32'(bus.dma_done), 32'd1);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0, 8'd0);
        dmaStimulus(1'b0, 1'b0, '0, 8'd0);
        #12;
        checkOutput("resetStrobes", 32'({_ce_ram, _we_mem, _lb, _ub, bdata_oe}), 32'b11110);
        checkOutput("resetBaddr", 32'(baddress), 32'd0);
        checkOutput("resetDma", 32'({bus.dma_done, bus.dma_abort, bus.dma_rdata}), 32'd0);
        @(negedge clock);
        _reset = 1'b1;
        tick();
        checkOutput("idleCe", 32'(_ce_ram), 32'd1);

        // Host write 0xA5 to 0x01235, then hold long enough to saturate ctr.
        applyStimulus(1'b1, 1'b1, 21'h01235, 8'hA5);
        tick();
        checkOutput("hostCe", 32'(_ce_ram), 32'd0);
        checkOutput("hostBaddr", 32'(baddress), 32'h091A);
        checkOutput("hostLanes", 32'({_lb, _ub}), 32'b10);
        checkOutput("hostWeClk1", 32'(_we_mem), 32'd1);
        tick();
        checkOutput("hostWeClk2", 32'(_we_mem), 32'd1);
        tick();
        checkOutput("hostWeClk3", 32'({_we_mem, bdata_oe}), 32'b01);
        checkOutput("hostWdata", 32'(bdata_out), 32'hA5A5);
        repeat (14) tick();
        checkOutput("hostWeSaturated", 32'(_we_mem), 32'd0);
        bus.host_req = 1'b0;
        tick();
        checkOutput("recoverStrobes", 32'({_ce_ram, _we_mem, _lb, _ub, bdata_oe}), 32'b11110);
        ref_mem[13'h1235] = 8'hA5;
        tick();

        // DMA read of 0x00010 with 0x3C7E in the word.
        preload      = 1'b1;
        preload_addr = 12'd8;
        preload_data = 16'h3C7E;
        tick();
        preload = 1'b0;
        ref_mem[16] = 8'h7E;
        ref_mem[17] = 8'h3C;
        dmaStimulus(1'b1, 1'b0, 21'h00010, 8'd0);
        tick();
        checkOutput("dmaGrant", 32'({_ce_ram, baddress}), 32'h8);
        tick();
        tick();
        checkOutput("dmaNotYetDone", 32'(bus.dma_done), 32'd0);
        tick();
        checkOutput("dmaDone", 32'(bus.dma_done), 32'd1);
        checkOutput("dmaRdata", 32'(bus.dma_rdata), 32'h7E);
        checkOutput("dmaRecover", 32'(_ce_ram), 32'd1);
        bus.dma_req = 1'b0;
        tick();
        checkOutput("dmaDonePulse", 32'(bus.dma_done), 32'd0);

        // Host arrives at DMA ctr=1 during a write: abort, then retry completes.
        dmaStimulus(1'b1, 1'b1, 21'h00401, 8'h5A);
        tick();
        checkOutput("dmaWeCtr0", 32'(_we_mem), 32'd1);
        tick();
        checkOutput("dmaWeCtr1", 32'({_we_mem, _ub}), 32'd0);
        applyStimulus(1'b1, 1'b0, 21'h00020, 8'd0);
        #1;
        checkOutput("abortWeForced", 32'({_we_mem, bdata_oe}), 32'b10);
        tick();
        checkOutput("abortPulse", 32'({bus.dma_abort, bus.dma_done}), 32'b10);
        checkOutput("abortHostBaddr", 32'({_ce_ram, baddress}), 32'h10);
        checkOutput("abortHostRdata", 32'(bus.host_rdata), 32'(ref_mem[32]));
        tick();
        checkOutput("abortPulseEnd", 32'(bus.dma_abort), 32'd0);
        bus.host_req = 1'b0;
        waitDone("retryDone", 12);
        checkOutput("rdataKeptOnWrite", 32'(bus.dma_rdata), 32'h7E);
        bus.dma_req = 1'b0;
        ref_mem[13'h401] = 8'h5A;
        tick();

        // Simultaneous requests from IDLE: host first, DMA after HOST and RECOVER.
        applyStimulus(1'b1, 1'b0, 21'h00030, 8'd0);
        dmaStimulus(1'b1, 1'b0, 21'h00401, 8'd0);
        tick();
        checkOutput("simulHostWins", 32'({_ce_ram, baddress}), 32'h18);
        tick();
        bus.host_req = 1'b0;
        tick();
        checkOutput("simulRecover", 32'(_ce_ram), 32'd1);
        tick();
        checkOutput("simulIdle", 32'(_ce_ram), 32'd1);
        tick();
        checkOutput("simulDmaGrant", 32'({_ce_ram, baddress}), 32'h200);
        waitDone("simulDmaDone", 8);
        checkOutput("simulDmaRdata", 32'(bus.dma_rdata), 32'h5A);
        bus.dma_req = 1'b0;
        tick();

        // Back-to-back host cycles with a 1-clock gap while DMA waits.
        applyStimulus(1'b1, 1'b0, 21'h00040, 8'd0);
        dmaStimulus(1'b1, 1'b0, 21'h00404, 8'd0);
        tick();
        tick();
        bus.host_req = 1'b0;
        tick();
        checkOutput("b2bRecover", 32'(_ce_ram), 32'd1);
        applyStimulus(1'b1, 1'b0, 21'h00042, 8'd0);
        tick();
        checkOutput("b2bHostAgain", 32'({_ce_ram, baddress}), 32'h21);
        bus.host_req = 1'b0;
        waitDone("b2bDmaDone", 10);
        checkOutput("b2bDmaRdata", 32'(bus.dma_rdata), 32'(ref_mem[13'h404]));
        bus.dma_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a DMA write strobe.
        dmaStimulus(1'b1, 1'b1, 21'h00406, 8'h11);
        tick();
        tick();
        checkOutput("preResetWe", 32'(_we_mem), 32'd0);
        #2;
        _reset = 1'b0;
        #1;
        checkOutput("asyncResetStrobes", 32'({_ce_ram, _we_mem, bdata_oe}), 32'b110);
        checkOutput("asyncResetDma", 32'({bus.dma_done, bus.dma_abort, bus.dma_rdata}), 32'd0);
        bus.dma_req = 1'b0;
        @(negedge clock);
        _reset = 1'b1;
        tick();
        checkOutput("postResetIdle", 32'(_ce_ram), 32'd1);

        // Random traffic: host bytes 0..1023, DMA bytes 1024..2047.
        fork
            begin
                fork
                    begin
                        logic [AW-1:0] a;
                        logic [7:0]    d;
                        bit            w;
                        int            len;
                        int            gap;
                        for (int i = 0; i < 30; i++) begin
                            a   = AW'($urandom_range(0, 1023));
                            d   = 8'($urandom);
                            w   = 1'($urandom_range(0, 1));
                            len = $urandom_range(3, 6);
                            gap = $urandom_range(0, 8);
                            if (w) ref_mem[a[12:0]] = d;
                            else host_q.push_back(ref_mem[a[12:0]]);
                            applyStimulus(1'b1, w, a, d);
                            repeat (len) tick();
                            bus.host_req = 1'b0;
                            tick();
                            repeat (gap) tick();
                        end
                    end
                    begin
                        logic [AW-1:0] a;
                        logic [7:0]    d;
                        bit            w;
                        int            n;
                        for (int i = 0; i < 30; i++) begin
                            repeat ($urandom_range(0, 4)) tick();
                            a = AW'($urandom_range(1024, 2047));
                            d = 8'($urandom);
                            w = 1'($urandom_range(0, 1));
                            if (w) ref_mem[a[12:0]] = d;
                            dma_q.push_back('{we: w, exp: ref_mem[a[12:0]]});
                            dmaStimulus(1'b1, w, a, d);
                            n = 0;
                            do begin
                                tick();
                                n++;
                            end while (!bus.dma_done && n < 1000);
                            if (!bus.dma_done) checkOutput("dmaTimeout", 32'(bus.dma_done), 32'd1);
                            bus.dma_req = 1'b0;
                        end
                    end
                join
                repeat (4) tick();
                stop_mon = 1'b1;
            end
            begin
                dma_exp_t de;
                bit [7:0] he;
                while (!stop_mon) begin
                    @(negedge clock);
                    if (!stop_mon) begin
                        if (bus.dma_done || bus.dma_abort)
                            checkOutput("doneAbortExclusive", 32'(bus.dma_done & bus.dma_abort), 32'd0);
                        if (bus.dma_done) begin
                            checkOutput("dmaQueueEmpty", 32'(dma_q.size() == 0), 32'd0);
                            if (dma_q.size() != 0) begin
                                de = dma_q.pop_front();
                                if (!de.we) checkOutput("randDmaRdata", 32'(bus.dma_rdata), 32'(de.exp));
                            end
                        end
                        if (!_ce_ram) begin
                            checkOutput("laneOneHot", 32'(_lb ^ _ub), 32'd1);
                            checkOutput("oeFollowsWe", 32'(bdata_oe), 32'(!_we_mem));
                        end
                        if (!_ce_ram && !bus.host_req && baddress < 512 && !bus.host_we) begin
                            checkOutput("hostQueueEmpty", 32'(host_q.size() == 0), 32'd0);
                            if (host_q.size() != 0) begin
                                he = host_q.pop_front();
                                checkOutput("randHostRdata", 32'(bus.host_rdata), 32'(he));
                            end
                        end
                    end
                end
            end
        join

        checkOutput("hostQueueLeft", 32'(host_q.size()), 32'd0);
        checkOutput("dmaQueueLeft", 32'(dma_q.size()), 32'd0);
        begin
            int mismatches;
            mismatches = 0;
            for (int i = 0; i < 4096; i++) begin
                if (mem[i][7:0] != ref_mem[2*i]) mismatches++;
                if (mem[i][15:8] != ref_mem[2*i+1]) mismatches++;
            end
            checkOutput("memImage", 32'(mismatches), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
